uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver that generalises the existing fixed 8N1 receiver to configurable data width, parity and stop bits. It adds 3-sample majority voting, framing, parity, overrun and break detection, and a valid/ready output handshake. It sits between the board `rx` pin and the Cipherbox command/data path, and feeds a consumer that may stall.

## Interface
- `CLKS_PER_BIT`, 434: clocks per bit period (50 MHz / 115200); legal ≥ 8
- `DATA_BITS`, 8: data bits per frame, legal 5–9, LSB first
- `PARITY`, 0: 0 none, 1 odd, 2 even
- `STOP_BITS`, 1: 1 or 2
- `clk`  in  1  single system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `rx`  in  1  asynchronous serial line, idle high
- `rx_data`  out  DATA_BITS  received word; valid while `rx_valid`
- `rx_valid`  out  1  holding register full
- `rx_ready`  in  1  consumer accepts when `rx_valid && rx_ready`
- `frame_err`  out  1  qualified by `rx_valid`; a stop bit sampled 0
- `parity_err`  out  1  qualified by `rx_valid`; parity mismatch (0 when `PARITY`=0)
- `overrun`  out  1  one-cycle pulse; completed frame dropped
- `break_det`  out  1  one-cycle pulse on break detection
- `rx_state`  out  3  current FSM state, for debug

## Operation
- `rx` passes through 2 flops (reset value 1) giving `rx_s`. All decisions use `rx_s`.
- Bit timer `cnt` counts 0..CLKS_PER_BIT-1 within each bit, then wraps. MID = CLKS_PER_BIT/2. Samples are taken at MID-1, MID and MID+1; the bit value is the majority, decided at MID+1.
- States (3-bit encoding): IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, BREAK=5.
- IDLE: when `rx_s`=0, go to START with `cnt`=0 and bit index 0.
- START: at the decision point, majority 1 means a false start, return to IDLE with nothing reported. Majority 0 means go to DATA at the next bit boundary.
- DATA: shift the decided bit into `shift[idx]`. After DATA_BITS bits, go to PARITY if `PARITY`≠0, else STOP.
- PARITY: compare against the XOR of the data bits (odd requires the total count of ones, including the parity bit, to be odd). Store the mismatch.
- STOP: decide each of the STOP_BITS bits. Any 0 sets the frame error.
- Frame completion at the decision of the final stop bit:
  - All data bits, parity bit (if present) and all stop bits are 0: treat as a break. Pulse `break_det`, deliver nothing, go to BREAK.
  - Otherwise, deliver the frame to the holding register and return to IDLE immediately (mid-stop resync).
- BREAK: stay until `rx_s`=1, then go to IDLE.
- Delivery:
  - Holding register empty, or drained in the same cycle: load `rx_data`, `frame_err` and `parity_err`, and set `rx_valid`.
  - Holding register full and not drained: drop the new frame, keep the old data and flags, pulse `overrun`.
- `rx_valid` clears on handshake when no new frame is loading that cycle.
- Framing-error frames that are not breaks are delivered with `frame_err`=1.

## Timing
- On `rst`:
  - State IDLE, `cnt`=0, sync flops at 1.
  - `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `break_det`=0, `rx_state`=0.
- Reset mid-frame abandons the frame. No `rx_valid`, `overrun` or `break_det` follows.
- Input latency: 2 cycles from the `rx` pin to `rx_s`. IDLE sees low 1 cycle later.
- Let N = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS.
  - `rx_valid` rises 1 cycle after the final-stop decision.
  - The final-stop decision occurs (N-1)·CLKS_PER_BIT + MID + 1 cycles after START entry.
- Simultaneous handshake and new delivery: the old word is consumed, the new word is loaded, `rx_valid` stays 1, and `overrun` stays 0.
- Back-to-back frames: a start edge is accepted from the first cycle back in IDLE, so there is no dead time beyond the half stop bit.
- `overrun` and `break_det` are never high for more than 1 cycle per event.
- Width rules:
  - `cnt` is `$clog2(CLKS_PER_BIT)` bits wide.
  - The bit index is `$clog2(DATA_BITS+1)` bits wide.
  - The majority is the 2-of-3 vote of the sample bits.

## Structure
- Package `uart_pkg`:
  - State encoding constants.
  - Parity mode constants (PAR_NONE, PAR_ODD, PAR_EVEN).
  - Default CLKS_PER_BIT.
- Sub-module `uart_rx_sampler`: synchroniser, bit timer and majority vote. It outputs the decided bit, a one-cycle `bit_tick` at MID+1, and `rx_s`. It takes a `restart` input that zeroes the timer.
- The top level holds the FSM, shift register, parity check, holding register and handshake.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- 8N1, send 0xA5 with `rx_ready`=1 → `rx_valid` 1-cycle pulse, `rx_data`=0xA5, both error flags 0.
- 8E1, send 0x37 with correct parity 1, then with parity 0 → 0x37 with `parity_err`=0, then 0x37 with `parity_err`=1.
- 7O2, send 0x55 with the second stop bit 0 → `rx_data`=0x55, `frame_err`=1. A 1-cycle glitch low inside a data bit at MID does not change the data (majority vote).
- `rx_ready`=0, send 0x11 then 0x22 → `rx_data` stays 0x11 and `overrun` pulses once. After `rx_ready`=1: handshake completes and `rx_valid`=0.
- `rx` held low for 12 bit times → `break_det` pulses once, no `rx_valid`. State stays BREAK until `rx` returns high. A following 0x3C is received correctly.
- A 4-cycle low pulse on idle `rx` is a false start → back to IDLE, nothing reported. Assert `rst` mid-frame of 0xFF → all outputs 0, no delivery. The next frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the configurable UART receiver: state encoding,
// parity modes and the default bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int DEF_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit timer and 3-sample majority vote.
// bit_tick marks the decision point (MID+1); bit_val is valid in that cycle.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic restart,
  output logic rx_s,
  output logic bit_val,
  output logic bit_tick
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_M1   = CW'(MID - 1);
  localparam logic [CW-1:0] C_MID  = CW'(MID);
  localparam logic [CW-1:0] C_P1   = CW'(MID + 1);

  logic          rx_m;
  logic [CW-1:0] cnt;
  logic          s0, s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      cnt  <= '0;
      s0   <= 1'b1;
      s1   <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      if (restart || cnt == C_LAST) cnt <= '0;
      else                          cnt <= cnt + 1'b1;
      if (cnt == C_M1)  s0 <= rx_s;
      if (cnt == C_MID) s1 <= rx_s;
    end
  end

  // Third sample is the live rx_s at MID+1, so the vote is ready that cycle.
  assign bit_tick = (cnt == C_P1);
  assign bit_val  = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: frame FSM, parity/framing/break checks and a
// single-entry holding register with valid/ready handshake.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic [2:0]           rx_state
);

  localparam int IW = $clog2(DATA_BITS + 1);

  rx_state_t            state;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shift;
  logic                 perr_q, ferr_q, zero_q;
  logic                 rx_s, bit_val, bit_tick, restart;
  logic                 fe_fin, zero_fin, drain;

  assign restart = (state == S_IDLE) && !rx_s;

  uart_rx_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .restart  (restart),
    .rx_s     (rx_s),
    .bit_val  (bit_val),
    .bit_tick (bit_tick)
  );

  // Flags as they stand once the bit being decided right now is included.
  assign fe_fin   = ferr_q | ~bit_val;
  assign zero_fin = zero_q & ~bit_val;
  assign drain    = rx_valid & rx_ready;
  assign rx_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      shift      <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b1;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      break_det <= 1'b0;
      if (drain) rx_valid <= 1'b0;
      case (state)
        S_IDLE: if (!rx_s) begin
          state  <= S_START;
          idx    <= '0;
          perr_q <= 1'b0;
          ferr_q <= 1'b0;
          zero_q <= 1'b1;
        end
        S_START: if (bit_tick) state <= bit_val ? S_IDLE : S_DATA;
        S_DATA: if (bit_tick) begin
          // LSB arrives first; after DATA_BITS shifts it sits in bit 0.
          shift <= {bit_val, shift[DATA_BITS-1:1]};
          if (bit_val) zero_q <= 1'b0;
          if (idx == IW'(DATA_BITS - 1)) begin
            idx   <= '0;
            state <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_PARITY: if (bit_tick) begin
          perr_q <= (PARITY == PAR_ODD) ? ~(^shift ^ bit_val) : (^shift ^ bit_val);
          if (bit_val) zero_q <= 1'b0;
          state <= S_STOP;
        end
        S_STOP: if (bit_tick) begin
          if (!bit_val) ferr_q <= 1'b1;
          if (bit_val)  zero_q <= 1'b0;
          if (idx == IW'(STOP_BITS - 1)) begin
            if (zero_fin) begin
              break_det <= 1'b1;
              state     <= S_BREAK;
            end else begin
              state <= S_IDLE;
              if (!rx_valid || drain) begin
                rx_data    <= shift;
                frame_err  <= fe_fin;
                parity_err <= perr_q;
                rx_valid   <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_BREAK: if (rx_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 8E1, 7O2) driven by
// directed and random frames, checked against a frame-level model.
module tb_uart_rx_cfg;

  localparam int CPB = 16;
  localparam int DB[3] = '{8, 8, 7};
  localparam int PM[3] = '{0, 2, 1};
  localparam int SB[3] = '{1, 1, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] rx, rdy, vld, fe, pe, ovr, brk;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [2:0] st0, st1, st2;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .rx(rx[0]), .rx_data(d0), .rx_valid(vld[0]), .rx_ready(rdy[0]),
    .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ovr[0]), .break_det(brk[0]), .rx_state(st0));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .rx(rx[1]), .rx_data(d1), .rx_valid(vld[1]), .rx_ready(rdy[1]),
    .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ovr[1]), .break_det(brk[1]), .rx_state(st1));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .rx(rx[2]), .rx_data(d2), .rx_valid(vld[2]), .rx_ready(rdy[2]),
    .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ovr[2]), .break_det(brk[2]), .rx_state(st2));

  function automatic logic [8:0] dat(int u);
    case (u)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      default: return {2'b0, d2};
    endcase
  endfunction

  function automatic logic [2:0] sta(int u);
    case (u)
      0:       return st0;
      1:       return st1;
      default: return st2;
    endcase
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         hs_cnt[3], ovr_cnt[3], brk_cnt[3], vld_cyc[3], rise_cyc[3];
  logic [8:0] hs_data[3];
  logic       hs_fe[3], hs_pe[3];
  logic [2:0] vld_d = '0;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i] && rdy[i]) begin
        hs_cnt[i]++;
        hs_data[i] = dat(i);
        hs_fe[i]   = fe[i];
        hs_pe[i]   = pe[i];
      end
      if (ovr[i]) ovr_cnt[i]++;
      if (brk[i]) brk_cnt[i]++;
      if (vld[i]) vld_cyc[i]++;
      if (vld[i] && !vld_d[i]) rise_cyc[i] = cyc;
    end
    vld_d = vld;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level model state for the most recent send().
  logic [8:0] e_data;
  logic       e_fe, e_pe, e_brk;
  int         e_n, f_start, b_hs, b_brk, b_ovr, b_vc;

  task automatic send(input int u, input int data, input bit par_bad,
                      input bit [1:0] stops, input int glitch);
    logic b[$];
    int   ones;
    bit   pb;
    ones = 0;
    b.push_back(1'b0);
    for (int i = 0; i < DB[u]; i++) begin
      b.push_back(data[i]);
      ones += data[i];
    end
    if (PM[u] != 0) begin
      pb = (PM[u] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
      b.push_back(pb ^ par_bad);
    end
    for (int i = 0; i < SB[u]; i++) b.push_back(stops[i]);
    e_data = 9'(data & ((1 << DB[u]) - 1));
    e_pe   = par_bad && (PM[u] != 0);
    e_fe   = 1'b0;
    for (int i = 0; i < SB[u]; i++) if (!stops[i]) e_fe = 1'b1;
    e_brk  = 1'b1;
    for (int k = 1; k < b.size(); k++) if (b[k]) e_brk = 1'b0;
    e_n   = b.size();
    b_hs  = hs_cnt[u];
    b_brk = brk_cnt[u];
    b_ovr = ovr_cnt[u];
    b_vc  = vld_cyc[u];
    f_start = cyc;
    for (int k = 0; k < b.size(); k++)
      for (int j = 0; j < CPB; j++) begin
        rx[u] = b[k] ^ (glitch >= 0 && k == glitch + 1 && j == CPB / 2 + 1);
        tick(1);
      end
    rx[u] = 1'b1;
    tick(24);
  endtask

  task automatic check_frame(input int u, input string tag);
    if (e_brk) begin
      chk({tag, "_brk"}, brk_cnt[u] - b_brk, 1);
      chk({tag, "_nohs"}, hs_cnt[u] - b_hs, 0);
    end else begin
      chk({tag, "_hs"}, hs_cnt[u] - b_hs, 1);
      chk({tag, "_data"}, hs_data[u], e_data);
      chk({tag, "_fe"}, hs_fe[u], e_fe);
      chk({tag, "_pe"}, hs_pe[u], e_pe);
    end
  endtask

  int oc, bb, bh, bo;

  initial begin
    rx  = 3'b111;
    rdy = 3'b111;
    rst = 1'b1;
    tick(3);
    for (int u = 0; u < 3; u++)
      chk("reset_outs", {vld[u], fe[u], pe[u], ovr[u], brk[u], sta(u), dat(u)}, 0);
    rst = 1'b0;
    tick(2);

    // 8N1 0xA5: one-cycle valid pulse, exact latency
    send(0, 'hA5, 0, 2'b11, -1);
    check_frame(0, "8n1_a5");
    chk("8n1_latency", rise_cyc[0] - f_start, (e_n - 1) * CPB + 13);
    chk("8n1_pulse", vld_cyc[0] - b_vc, 1);

    // 8E1 0x37 good parity then bad parity
    send(1, 'h37, 0, 2'b11, -1);
    check_frame(1, "8e1_good");
    send(1, 'h37, 1, 2'b11, -1);
    check_frame(1, "8e1_bad");

    // 7O2 0x55 with second stop low, then a mid-bit glitch
    send(2, 'h55, 0, 2'b01, -1);
    check_frame(2, "7o2_stop2");
    send(2, 'h55, 0, 2'b11, 2);
    check_frame(2, "7o2_glitch");
    chk("7o2_latency", rise_cyc[2] - f_start, (e_n - 1) * CPB + 13);

    // overrun: stalled consumer, second frame dropped
    rdy[0] = 1'b0;
    oc = ovr_cnt[0];
    bh = hs_cnt[0];
    send(0, 'h11, 0, 2'b11, -1);
    send(0, 'h22, 0, 2'b11, -1);
    chk("ovr_data", dat(0), 'h11);
    chk("ovr_valid", vld[0], 1);
    chk("ovr_pulses", ovr_cnt[0] - oc, 1);
    rdy[0] = 1'b1;
    tick(1);
    chk("ovr_drain_hs", hs_cnt[0] - bh, 1);
    chk("ovr_drain_data", hs_data[0], 'h11);
    chk("ovr_drain_valid", vld[0], 0);

    // break: line low for 12 bit times
    bb = brk_cnt[0];
    bh = hs_cnt[0];
    rx[0] = 1'b0;
    tick(12 * CPB);
    chk("brk_state", sta(0), 5);
    chk("brk_pulses", brk_cnt[0] - bb, 1);
    chk("brk_nohs", hs_cnt[0] - bh, 0);
    chk("brk_novalid", vld[0], 0);
    rx[0] = 1'b1;
    tick(4);
    chk("brk_exit", sta(0), 0);
    send(0, 'h3C, 0, 2'b11, -1);
    check_frame(0, "after_brk");

    // false start: 4-cycle low pulse
    bh = hs_cnt[0];
    bb = brk_cnt[0];
    rx[0] = 1'b0;
    tick(4);
    rx[0] = 1'b1;
    tick(6);
    chk("fs_in_start", sta(0), 1);
    tick(30);
    chk("fs_idle", sta(0), 0);
    chk("fs_nohs", hs_cnt[0] - bh, 0);
    chk("fs_nobrk", brk_cnt[0] - bb, 0);
    chk("fs_novalid", vld[0], 0);

    // reset in the middle of a 0xFF frame
    bh = hs_cnt[0];
    bb = brk_cnt[0];
    bo = ovr_cnt[0];
    rx[0] = 1'b0;
    tick(CPB);
    rx[0] = 1'b1;
    tick(40);
    rst = 1'b1;
    tick(1);
    chk("midrst_outs", {vld[0], fe[0], pe[0], ovr[0], brk[0], sta(0), dat(0)}, 0);
    rst = 1'b0;
    tick(200);
    chk("midrst_nohs", hs_cnt[0] - bh, 0);
    chk("midrst_noevt", (brk_cnt[0] - bb) + (ovr_cnt[0] - bo), 0);
    send(0, 'hC3, 0, 2'b11, -1);
    check_frame(0, "after_rst");

    // random frames on every configuration
    for (int u = 0; u < 3; u++)
      for (int n = 0; n < 6; n++) begin
        int       data;
        bit       pbad;
        bit [1:0] stops;
        data  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom);
        pbad  = 1'($urandom_range(0, 1));
        stops = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        send(u, data, pbad, stops, -1);
        check_frame(u, "rand");
      end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
